divisor_sum_classifier: RTL and testbench

Parametrised sequential classifier that computes the sum of proper divisors of an unsigned input.
- Reports the input as deficient, perfect or abundant.
- Uses a start/busy/done handshake.
- Implemented as a single FSM with datapath registers: candidate divisor counter, remainder by repeated subtraction, divisor-sum accumulator.
- Optional early exit declares "abundant" as soon as the running sum exceeds the number.
- Sits beside the existing perfect-number controller as its general-width, multi-class replacement.

---
 rtl/divisor_sum_classifier_if.sv | 11 +
 rtl/divisor_sum_classifier.sv | 64 ++++++
 tb/tb_divisor_sum_classifier.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/divisor_sum_classifier_if.sv
// divisor_sum_classifier_if: start/busy/done handshake and result bus for the divisor-sum classifier
interface divisor_sum_classifier_if #(parameter int WIDTH = 14);
  logic             start;
  logic [WIDTH-1:0] num;
  logic             busy;
  logic             done;
  logic [1:0]       cls;
  logic [WIDTH+1:0] div_sum;
  modport master (output start, num, input busy, done, cls, div_sum);
  modport slave  (input start, num, output busy, done, cls, div_sum);
endinterface

// File: rtl/divisor_sum_classifier.sv
// divisor_sum_classifier: sequential proper-divisor sum with deficient/perfect/abundant classification
module divisor_sum_classifier #(
  parameter int WIDTH      = 14,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic clk,
  input logic rst,
  divisor_sum_classifier_if.slave bus
);
  typedef enum logic [2:0] {IDLE, INIT, CHECK, SUB, TEST, FINAL} state_t;
  state_t state;
  logic [WIDTH-1:0] n, cnt, rem;
  logic [WIDTH+1:0] sum, sum_nxt, n_ext;
  assign n_ext   = {2'b00, n};
  assign sum_nxt = (rem == '0) ? sum + {2'b00, cnt} : sum;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      n           <= '0;
      cnt         <= '0;
      rem         <= '0;
      sum         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.cls     <= 2'b00;
      bus.div_sum <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          n        <= bus.num;
          bus.busy <= 1'b1;
          state    <= INIT;
        end
        INIT: begin
          sum   <= (n > WIDTH'(1)) ? (WIDTH+2)'(1) : '0;
          cnt   <= WIDTH'(2);
          state <= CHECK;
        end
        CHECK: if (cnt > (n >> 1)) state <= FINAL;
        else begin
          rem   <= n;
          state <= SUB;
        end
        SUB: if (rem >= cnt) rem <= rem - cnt;
        else state <= TEST;
        // early exit uses the freshly updated sum, not the registered one
        TEST: begin
          sum   <= sum_nxt;
          cnt   <= cnt + WIDTH'(1);
          state <= (EARLY_EXIT && sum_nxt > n_ext) ? FINAL : CHECK;
        end
        FINAL: begin
          bus.div_sum <= sum;
          bus.cls     <= (n == '0) ? 2'b11 : (sum < n_ext) ? 2'b00 : (sum == n_ext) ? 2'b01 : 2'b10;
          bus.done    <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divisor_sum_classifier.sv
// tb_divisor_sum_classifier: scoreboard bench, dut a with early exit, dut b with full scan
module tb_divisor_sum_classifier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  typedef struct {
    logic [15:0] sum;
    logic [1:0]  cls;
    int          lat;
  } exp_t;
  exp_t q[$];

  divisor_sum_classifier_if #(.WIDTH(14)) ia ();
  divisor_sum_classifier_if #(.WIDTH(14)) ib ();

  divisor_sum_classifier #(.WIDTH(14), .EARLY_EXIT(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  divisor_sum_classifier #(.WIDTH(14), .EARLY_EXIT(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  always #5 clk = ~clk;

  // independent reference: trial division by modulo, latency counted in rising edges from the accepting edge
  task automatic model(input int n, input bit early, output exp_t e);
    int  sm;
    bit  ex;
    sm = (n > 1) ? 1 : 0;
    ex = 1'b0;
    e.lat = 3;
    for (int k = 2; k <= n / 2 && !ex; k++) begin
      e.lat += n / k + 3;
      if (n % k == 0) sm += k;
      if (early && sm > n) ex = 1'b1;
    end
    if (!ex) e.lat++;
    e.sum = 16'(sm);
    e.cls = (n == 0) ? 2'b11 : (sm < n) ? 2'b00 : (sm == n) ? 2'b01 : 2'b10;
  endtask

  // caller is positioned between edges; the next rising edge accepts the request
  task automatic issue(input int w, input int n);
    exp_t e;
    model(n, w == 0, e);
    q.push_back(e);
    if (w == 0) begin ia.start = 1'b1; ia.num = 14'(n); end
    else begin ib.start = 1'b1; ib.num = 14'(n); end
    @(posedge clk);
    #1;
    ia.start = 1'b0;
    ib.start = 1'b0;
  endtask

  task automatic wait_done(input int w, input int lat0, output int lat, output logic [15:0] s,
                           output logic [1:0] c, output logic bz);
    lat = lat0;
    s = 'x; c = 'x; bz = 'x;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if ((w == 0) ? ia.done : ib.done) begin
        s  = (w == 0) ? ia.div_sum : ib.div_sum;
        c  = (w == 0) ? ia.cls : ib.cls;
        bz = (w == 0) ? ia.busy : ib.busy;
        return;
      end
      if (lat > 20000) begin
        lat = -1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({ia.busy, ia.done, ia.cls, ia.div_sum} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_a: busy/done/cls/sum=%0b/%0b/%0b/%0d want all 0", ia.busy, ia.done, ia.cls, ia.div_sum);
    end
    compared++;
    if ({ib.busy, ib.done, ib.cls, ib.div_sum} !== 20'h0) begin
      mismatched++;
      $display("FAIL reset_b: busy/done/cls/sum=%0b/%0b/%0b/%0d want all 0", ib.busy, ib.done, ib.cls, ib.div_sum);
    end
    rst = 1'b0;
  endtask

  task automatic test_single(input int w, input int n);
    int lat;
    logic [15:0] s;
    logic [1:0] c;
    logic bz;
    exp_t e;
    issue(w, n);
    wait_done(w, 1, lat, s, c, bz);
    e = q.pop_front();
    compared++;
    if (c !== e.cls || s !== e.sum || lat != e.lat) begin
      mismatched++;
      $display("FAIL single_%0d_n%0d: cls=%0b sum=%0d lat=%0d want cls=%0b sum=%0d lat=%0d", w, n, c, s, lat, e.cls, e.sum, e.lat);
    end
    compared++;
    if (bz !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_in_done_n%0d: busy=%0b want 0", n, bz);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] s;
    logic [1:0] c;
    logic bz;
    exp_t e;
    issue(0, 28);
    wait_done(0, 1, lat, s, c, bz);
    issue(0, 496);
    e = q.pop_front();
    compared++;
    if (c !== e.cls || s !== e.sum || lat != e.lat) begin
      mismatched++;
      $display("FAIL b2b_first: cls=%0b sum=%0d lat=%0d want cls=%0b sum=%0d lat=%0d", c, s, lat, e.cls, e.sum, e.lat);
    end
    wait_done(0, 1, lat, s, c, bz);
    e = q.pop_front();
    compared++;
    if (c !== e.cls || s !== e.sum || lat != e.lat) begin
      mismatched++;
      $display("FAIL b2b_second: cls=%0b sum=%0d lat=%0d want cls=%0b sum=%0d lat=%0d", c, s, lat, e.cls, e.sum, e.lat);
    end
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (ia.cls !== 2'b01 || ia.div_sum !== 16'd496 || ia.done !== 1'b0) begin
      mismatched++;
      $display("FAIL hold: cls=%0b sum=%0d done=%0b want cls=01 sum=496 done=0", ia.cls, ia.div_sum, ia.done);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    int bad = 0;
    logic [15:0] s;
    logic [1:0] c;
    logic bz;
    exp_t e;
    issue(0, 28);
    for (int i = 0; i < 5; i++) begin
      ia.start = 1'b1;
      ia.num = 14'($urandom_range(0, 16383));
      @(posedge clk);
      #1;
      if (ia.busy !== 1'b1) bad++;
    end
    ia.start = 1'b0;
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL busy_high: busy low in %0d cycles want 0", bad);
    end
    wait_done(0, 6, lat, s, c, bz);
    e = q.pop_front();
    compared++;
    if (c !== e.cls || s !== e.sum || lat != e.lat) begin
      mismatched++;
      $display("FAIL ignore_busy: cls=%0b sum=%0d lat=%0d want cls=%0b sum=%0d lat=%0d", c, s, lat, e.cls, e.sum, e.lat);
    end
  endtask

  task automatic test_abort();
    int pulses = 0;
    exp_t e;
    issue(0, 496);
    e = q.pop_front();
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    compared++;
    if ({ia.busy, ia.done, ia.cls, ia.div_sum} !== 20'h0) begin
      mismatched++;
      $display("FAIL abort_outputs: busy/done/cls/sum=%0b/%0b/%0b/%0d want all 0", ia.busy, ia.done, ia.cls, ia.div_sum);
    end
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (ia.done || ia.busy) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL abort_quiet: %0d busy/done cycles want 0 (dropped sum %0d)", pulses, e.sum);
    end
    test_single(0, 12);
  endtask

  initial begin
    ia.start = 1'b0; ia.num = '0;
    ib.start = 1'b0; ib.num = '0;
    test_reset();
    test_single(0, 6);
    test_back_to_back();
    test_single(0, 8);
    test_single(0, 1);
    test_single(0, 0);
    test_single(0, 36);
    test_single(1, 36);
    test_single(1, 1);
    test_ignore_busy();
    test_abort();
    for (int i = 0; i < 6; i++) test_single(i % 2, int'($urandom_range(2, 2000)));
    test_single(1, 12);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
